window_scan_ctrl: RTL
=====================

WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 Parameter IMG_W, default 640: pixels per image row; legal range 3..2^CNT_W.
REQ-002 Parameter IMG_H, default 480: rows per frame; legal range 3..2^CNT_W.
REQ-003 Parameter CNT_W, default 10: width of the row, column and address counters.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  frame start request; sampled only in IDLE.
REQ-007 abort  input  1  synchronous frame abort.
REQ-008 in_valid  input  1  upstream pixel available (raster order).
REQ-009 in_ready  output  1  controller accepts the pixel this cycle.
REQ-010 out_ready  input  1  downstream consumes win_valid this cycle.
REQ-011 win_enable  output  1  shift enable to the 3x3 window register array.
REQ-012 win_valid  output  1  window array holds a complete in-image 3x3 window.
REQ-013 win_row, win_col  output  CNT_W each  centre coordinates of the current window.
REQ-014 lb_wr_en  output  1  line-buffer write strobe; lb_addr  output  CNT_W  line-buffer column address.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: start=1 and abort=0 SHALL move to RUN with the row and column counters at 0.
REQ-019 RUN: in_ready SHALL equal (!win_valid | out_ready); accept = in_valid & in_ready.
REQ-020 In every state other than RUN, in_ready SHALL be 0.
REQ-021 win_enable, lb_wr_en SHALL equal accept (combinational); lb_addr SHALL equal the current column counter.
REQ-022 On accept, col SHALL increment; at col=IMG_W-1 col SHALL wrap to 0 and row SHALL increment.
REQ-023 On accept of pixel (row,col), on the next edge win_valid SHALL become (row>=2 & col>=2), win_row SHALL become row-1 and win_col SHALL become col-1 (1-cycle latency).
REQ-024 Without accept, win_valid SHALL clear when out_ready=1 and SHALL hold otherwise; win_row/win_col SHALL hold.
REQ-025 Accept and out_ready in the same cycle SHALL load the new window with no bubble.
REQ-026 Accept of pixel (IMG_H-1, IMG_W-1) SHALL move RUN to DRAIN; counters SHALL return to 0.
REQ-027 DRAIN SHALL move to DONE when win_valid=0, or when win_valid=1 and out_ready=1.
REQ-028 DONE SHALL assert frame_done for exactly one cycle, then move to IDLE.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 abort=1 in any state SHALL, on the next edge, force IDLE, zero the counters and clear win_valid; frame_done SHALL NOT pulse.
REQ-031 abort and start asserted together SHALL behave as abort.
REQ-032 Counters SHALL never exceed IMG_W-1 / IMG_H-1; no arithmetic wraps except the column wrap in REQ-022.

Reset
REQ-033 While rst=0, state SHALL be IDLE and every output SHALL be 0: in_ready, win_enable, win_valid, win_row, win_col, lb_wr_en, lb_addr, busy, frame_done.
REQ-034 Reset mid-frame SHALL discard the frame with no frame_done; operation resumes only on a new start after rst=1.

Verification
REQ-035 IMG_W=4, IMG_H=3, in_valid=1, out_ready=1 -> 12 accepts on consecutive cycles; win_valid on exactly 2 cycles with centres (1,1) then (1,2); one frame_done pulse; busy low afterwards.
REQ-036 Same config, out_ready=0 when the first window appears -> win_valid holds (1,1), in_ready=0, win_enable=0 until out_ready=1; no pixel is lost or duplicated.
REQ-037 in_valid toggled 1/0 every cycle -> counters advance only on accept; window coordinates identical to REQ-035.
REQ-038 abort asserted after the 7th accept -> IDLE next cycle, win_valid=0, counters 0, no frame_done; a following start runs a complete frame.
REQ-039 rst=0 pulsed asynchronously mid-RUN -> all outputs 0 immediately; start pulsed in RUN -> no effect.
REQ-040 Two back-to-back frames with start asserted in the cycle after frame_done -> second frame reproduces REQ-035 exactly.

Source files
------------

// File: rtl/window_scan_ctrl.sv
// Raster-scan controller for a 3x3 sliding-window engine: it accepts pixels, steers
// line-buffer writes and window-register shifts, and tracks window validity and centres.
module window_scan_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             win_enable,
    output logic             win_valid,
    output logic [CNT_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    output logic             lb_wr_en,
    output logic [CNT_W-1:0] lb_addr,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic             win_valid_q, win_valid_d;
    logic [CNT_W-1:0] win_row_q, win_row_d;
    logic [CNT_W-1:0] win_col_q, win_col_d;
    logic             in_ready_s;
    logic             accept_s;

    // Handshake: a held window blocks new pixels until downstream takes it.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_q == S_RUN) begin
            in_ready_s = !win_valid_q || out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
    end

    // Next-state logic for the FSM, the scan counters and the window tracker.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        if (abort) begin
            state_d     = S_IDLE;
            row_d       = ZERO;
            col_d       = ZERO;
            win_valid_d = 1'b0;
            win_row_d   = ZERO;
            win_col_d   = ZERO;
        end else begin
            // Centre lags the newest pixel by one in each axis; clamp keeps row/col 0 from wrapping.
            if (accept_s) begin
                win_valid_d = (row_q >= TWO) && (col_q >= TWO);
                win_row_d   = (row_q == ZERO) ? ZERO : row_q - ONE;
                win_col_d   = (col_q == ZERO) ? ZERO : col_q - ONE;
            end else if (out_ready) begin
                win_valid_d = 1'b0;
            end else begin
                win_valid_d = win_valid_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        row_d   = ZERO;
                        col_d   = ZERO;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (accept_s) begin
                        if (col_q == COL_LAST) begin
                            col_d = ZERO;
                            if (row_q == ROW_LAST) begin
                                row_d   = ZERO;
                                state_d = S_DRAIN;
                            end else begin
                                row_d = row_q + ONE;
                            end
                        end else begin
                            col_d = col_q + ONE;
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (!win_valid_q || out_ready) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            row_q       <= ZERO;
            col_q       <= ZERO;
            win_valid_q <= 1'b0;
            win_row_q   <= ZERO;
            win_col_q   <= ZERO;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign win_enable = accept_s;
    assign lb_wr_en   = accept_s;
    assign lb_addr    = col_q;
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);

endmodule
